// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: sequential PC generation, 1-cycle imem reads and a
// circular decoupling queue toward decode. Optional counters: FETCH_PERF_CNT_EN.
module fetch_queue_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              out_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] issued_pc;
  logic              inflight;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  logic [ADDR_W-1:0] q_pc    [DEPTH];
  logic [DATA_W-1:0] q_instr [DEPTH];

  logic [CNT_W:0]    credit_used;
  logic              has_space;
  logic              issue;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] redirect_target;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    else                        return p + PTR_W'(1);
  endfunction

  // A fetch reserves its queue slot at issue time, so a push always fits.
  assign credit_used     = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign has_space       = credit_used < (CNT_W + 1)'(DEPTH);
  assign issue           = !RST && !redirect_valid && has_space;
  assign push            = inflight && !redirect_valid;
  assign pop             = out_valid && out_ready;
  assign redirect_target = redirect_pc & ~ADDR_W'(3);

  assign imem_en   = issue;
  assign imem_addr = fetch_pc;
  assign out_valid = (count != '0);
  assign out_pc    = q_pc[rd_ptr];
  assign out_instr = q_instr[rd_ptr];

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc  <= RESET_PC;
      issued_pc <= RESET_PC;
      inflight  <= 1'b0;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_target;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc  <= fetch_pc + ADDR_W'(4);
        issued_pc <= fetch_pc;
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && push) begin
      q_pc[wr_ptr]    <= issued_pc;
      q_instr[wr_ptr] <= imem_rdata;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic stall;

  // Stall counts only credit back-pressure, never reset or redirect cycles.
  assign stall = !RST && !redirect_valid && !has_space;

  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (pop)   perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`else
  // No performance counters in this build.
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Table-driven bench for fetch_queue_unit plus hand sequences for PC wrap and,
// when FETCH_PERF_CNT_EN is defined, the performance counters.
module tb_fetch_queue_unit;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        exp_en;
    logic [31:0] exp_addr;
    logic        chk_out;
    logic        exp_v;
    logic [31:0] exp_pc;
  } vec_t;

  localparam logic [31:0] SIG = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rv  = 1'b0;
  logic [31:0] rpc = '0;
  logic        rdy = 1'b0;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  logic        w_rst = 1'b1;
  logic        w_en;
  logic [31:0] w_addr;
  logic [31:0] w_rdata = '0;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] m_pf, m_ps;
`endif

  fetch_queue_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0)) u_dut (
    .CLK(clk), .RST(rst), .redirect_valid(rv), .redirect_pc(rpc),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_ready(rdy)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(m_pf), .perf_stall_cnt(m_ps)
`endif
  );

  fetch_queue_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .CLK(clk), .RST(w_rst), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_en(w_en), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .out_valid(w_valid), .out_instr(w_instr), .out_pc(w_pc), .out_ready(1'b1)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt(), .perf_stall_cnt()
`endif
  );

  // Synchronous instruction memories with mem[a] = a ^ SIG.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= imem_addr ^ SIG;
    if (w_en)    w_rdata    <= w_addr ^ SIG;
  end

`ifdef FETCH_PERF_CNT_EN
  logic        p_rst = 1'b1;
  logic        p_en;
  logic [31:0] p_addr;
  logic [31:0] p_rdata = '0;
  logic        p_valid;
  logic [31:0] p_instr, p_pc;
  logic [31:0] p_fetch, p_stall;

  fetch_queue_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(2), .RESET_PC(32'h0)) u_perf (
    .CLK(clk), .RST(p_rst), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_en(p_en), .imem_addr(p_addr), .imem_rdata(p_rdata),
    .out_valid(p_valid), .out_instr(p_instr), .out_pc(p_pc), .out_ready(1'b1),
    .perf_fetch_cnt(p_fetch), .perf_stall_cnt(p_stall)
  );

  always @(posedge clk) if (p_en) p_rdata <= p_addr ^ SIG;
`endif

  function automatic vec_t mk(input logic r, input logic rd, input logic v, input logic [31:0] rp,
                              input logic en, input logic [31:0] a, input logic c,
                              input logic ov, input logic [31:0] pc);
    vec_t t;
    t.rst = r; t.rdy = rd; t.rv = v; t.rpc = rp;
    t.exp_en = en; t.exp_addr = a; t.chk_out = c; t.exp_v = ov; t.exp_pc = pc;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t t);
    @(negedge clk);
    rst = t.rst; rdy = t.rdy; rv = t.rv; rpc = t.rpc;
    #1;
  endtask

  task automatic checkOutput(input int idx, input vec_t t);
    check($sformatf("row%0d imem_en", idx), {31'b0, imem_en}, {31'b0, t.exp_en});
    if (t.exp_en) check($sformatf("row%0d imem_addr", idx), imem_addr, t.exp_addr);
    if (t.chk_out) begin
      check($sformatf("row%0d out_valid", idx), {31'b0, out_valid}, {31'b0, t.exp_v});
      if (t.exp_v) begin
        check($sformatf("row%0d out_pc", idx), out_pc, t.exp_pc);
        check($sformatf("row%0d out_instr", idx), out_instr, t.exp_pc ^ SIG);
      end
    end
  endtask

  initial begin
    // Reset, then free-running stream.
    vecs.push_back(mk(1,0,0,0, 0,0,     0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0,     1,0,0));
    vecs.push_back(mk(0,1,0,0, 1,0,     1,0,0));
    vecs.push_back(mk(0,1,0,0, 1,4,     1,0,0));
    vecs.push_back(mk(0,1,0,0, 1,8,     1,1,0));
    vecs.push_back(mk(0,1,0,0, 1,12,    1,1,4));
    vecs.push_back(mk(0,1,0,0, 1,16,    1,1,8));
    vecs.push_back(mk(0,1,0,0, 1,20,    1,1,12));
    // RST together with redirect: reset wins.
    vecs.push_back(mk(1,1,1,32'h200, 0,0, 0,0,0));
    vecs.push_back(mk(0,1,0,0, 1,0,     1,0,0));
    vecs.push_back(mk(0,1,0,0, 1,4,     1,0,0));
    vecs.push_back(mk(0,1,0,0, 1,8,     1,1,0));
    vecs.push_back(mk(0,1,0,0, 1,12,    1,1,4));
    // Back-pressure: fill to DEPTH, hold head, then drain in order.
    vecs.push_back(mk(1,0,0,0, 0,0,     0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0,     1,0,0));
    vecs.push_back(mk(0,0,0,0, 1,0,     1,0,0));
    vecs.push_back(mk(0,0,0,0, 1,4,     1,0,0));
    vecs.push_back(mk(0,0,0,0, 1,8,     1,1,0));
    vecs.push_back(mk(0,0,0,0, 1,12,    1,1,0));
    vecs.push_back(mk(0,0,0,0, 0,0,     1,1,0));
    vecs.push_back(mk(0,0,0,0, 0,0,     1,1,0));
    vecs.push_back(mk(0,1,0,0, 0,0,     1,1,0));
    vecs.push_back(mk(0,1,0,0, 1,16,    1,1,4));
    vecs.push_back(mk(0,1,0,0, 1,20,    1,1,8));
    vecs.push_back(mk(0,1,0,0, 1,24,    1,1,12));
    vecs.push_back(mk(0,1,0,0, 1,28,    1,1,16));
    // Redirect with 3 queued and 1 in flight, then back-to-back redirects.
    vecs.push_back(mk(1,0,0,0, 0,0,     0,0,0));
    vecs.push_back(mk(1,0,0,0, 0,0,     1,0,0));
    vecs.push_back(mk(0,0,0,0, 1,0,     1,0,0));
    vecs.push_back(mk(0,0,0,0, 1,4,     1,0,0));
    vecs.push_back(mk(0,0,0,0, 1,8,     1,1,0));
    vecs.push_back(mk(0,0,0,0, 1,12,    1,1,0));
    vecs.push_back(mk(0,0,1,32'h102, 0,0, 1,1,0));
    vecs.push_back(mk(0,1,0,0, 1,32'h100, 1,0,0));
    vecs.push_back(mk(0,1,0,0, 1,32'h104, 1,0,0));
    vecs.push_back(mk(0,1,0,0, 1,32'h108, 1,1,32'h100));
    vecs.push_back(mk(0,1,0,0, 1,32'h10C, 1,1,32'h104));
    vecs.push_back(mk(0,1,1,32'h40, 0,0,  1,1,32'h108));
    vecs.push_back(mk(0,1,1,32'h83, 0,0,  1,0,0));
    vecs.push_back(mk(0,1,0,0, 1,32'h80,  1,0,0));
    vecs.push_back(mk(0,1,0,0, 1,32'h84,  1,0,0));
    vecs.push_back(mk(0,1,0,0, 1,32'h88,  1,1,32'h80));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i]);
    end

    // PC wrap from the top of the address space.
    @(negedge clk); w_rst = 1'b0; #1;
    check("wrap issue0 en", {31'b0, w_en}, 32'd1);
    check("wrap issue0 addr", w_addr, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    check("wrap issue1 addr", w_addr, 32'h0000_0000);
    @(negedge clk); #1;
    check("wrap head0 valid", {31'b0, w_valid}, 32'd1);
    check("wrap head0 pc", w_pc, 32'hFFFF_FFFC);
    check("wrap head0 instr", w_instr, 32'hFFFF_FFFC ^ SIG);
    @(negedge clk); #1;
    check("wrap head1 pc", w_pc, 32'h0000_0000);
    check("wrap head1 instr", w_instr, SIG);

`ifdef FETCH_PERF_CNT_EN
    begin
      int xfers = 0;
      @(negedge clk); #1;
      check("perf reset fetch", p_fetch, 32'd0);
      check("perf reset stall", p_stall, 32'd0);
      @(negedge clk); p_rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
        #1;
        if (p_valid) xfers++;
        @(negedge clk);
      end
      #1;
      check("perf fetch count", p_fetch, 32'(xfers));
      check("perf stall nonzero", {31'b0, (p_stall != 32'd0)}, 32'd1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
